// File: rtl/ram_dp_bist.sv
// BIST initiator for ram_dp: bulk clear, zero check, pattern write on port A,
// pattern read-back on port B, with first-failure capture.
module ram_dp_bist #(
  parameter int              WIDTH  = 16,
  parameter int              DEPTH  = 16,
  parameter int              ADDR_W = 4,
  parameter logic [WIDTH-1:0] SEED  = 16'hA5A5,
  parameter int              CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [WIDTH-1:0]  fail_data,
  output logic              a_we,
  output logic [ADDR_W-1:0] a_addr,
  output logic [WIDTH-1:0]  a_din,
  output logic              b_we,
  output logic [ADDR_W-1:0] b_addr,
  output logic [WIDTH-1:0]  b_din,
  input  logic [WIDTH-1:0]  b_dout,
  output logic              clear_start,
  input  logic              clear_busy,
  input  logic              clear_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR_REQ,
    S_CLR_WAIT,
    S_ZCHK,
    S_WR,
    S_RD,
    S_FIN
  } state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  function automatic logic [WIDTH-1:0] pat(
    input logic [ADDR_W-1:0] a
  );
    return SEED ^ WIDTH'(a);
  endfunction

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               drain_q, drain_d;
  logic               cvld_q, cvld_d;
  logic [ADDR_W-1:0]  caddr_q, caddr_d;
  logic [WIDTH-1:0]   cexp_q, cexp_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [ADDR_W-1:0]  faddr_q, faddr_d;
  logic [WIDTH-1:0]   fdata_q, fdata_d;
  logic               awe_q, awe_d;
  logic [ADDR_W-1:0]  aaddr_q, aaddr_d;
  logic [WIDTH-1:0]   adin_q, adin_d;
  logic [ADDR_W-1:0]  baddr_q, baddr_d;
  logic               clr_q, clr_d;
  logic               mism;
  logic               issue_d;
  logic               unused_clear_busy;

  assign unused_clear_busy = clear_busy;

  assign mism = cvld_q && (b_dout != cexp_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    cvld_d  = 1'b0;
    caddr_d = caddr_q;
    cexp_d  = cexp_q;
    busy_d  = busy_q;
    pass_d  = pass_q;
    err_d   = err_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    if (mism) begin
      if (err_q != '1) err_d = err_q + CNT_W'(1);
      if (err_q == '0) begin
        faddr_d = caddr_q;
        fdata_d = b_dout;
      end
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR_REQ;
          busy_d  = 1'b1;
          err_d   = '0;
          pass_d  = 1'b0;
          faddr_d = '0;
          fdata_d = '0;
          cnt_d   = '0;
          drain_d = 1'b0;
        end
      end
      S_CLR_REQ:  state_d = S_CLR_WAIT;
      S_CLR_WAIT: if (clear_done) state_d = S_ZCHK;
      S_ZCHK, S_RD: begin
        if (!drain_q) begin
          cvld_d  = 1'b1;
          caddr_d = cnt_q;
          cexp_d  = (state_q == S_ZCHK) ? '0 : pat(cnt_q);
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            drain_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end else begin
          drain_d = 1'b0;
          state_d = (state_q == S_ZCHK) ? S_WR : S_FIN;
        end
      end
      S_WR: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_RD;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        pass_d  = (err_q == '0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // RAM-side outputs are registered from the next state so they align
  // with the state they belong to.
  assign issue_d = ((state_d == S_ZCHK) || (state_d == S_RD)) && !drain_d;
  assign done_d  = (state_d == S_FIN);
  assign clr_d   = (state_d == S_CLR_REQ);
  assign awe_d   = (state_d == S_WR);
  assign aaddr_d = awe_d ? cnt_d : '0;
  assign adin_d  = awe_d ? pat(cnt_d) : '0;
  assign baddr_d = issue_d ? cnt_d : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      cvld_q  <= 1'b0;
      caddr_q <= '0;
      cexp_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
      awe_q   <= 1'b0;
      aaddr_q <= '0;
      adin_q  <= '0;
      baddr_q <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      cvld_q  <= cvld_d;
      caddr_q <= caddr_d;
      cexp_q  <= cexp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      awe_q   <= awe_d;
      aaddr_q <= aaddr_d;
      adin_q  <= adin_d;
      baddr_q <= baddr_d;
      clr_q   <= clr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign fail_addr   = faddr_q;
  assign fail_data   = fdata_q;
  assign a_we        = awe_q;
  assign a_addr      = aaddr_q;
  assign a_din       = adin_q;
  assign b_we        = 1'b0;
  assign b_addr      = baddr_q;
  assign b_din       = '0;
  assign clear_start = clr_q;

endmodule
